ppi_bus_ctrl: RTL and testbench

- Synchronous bus-interface and control-register stage of the 8255A PPI.
- Sits directly upstream of the port-C-upper, port-C-lower, port-A and port-B blocks. Supplies `controlword`, the port output latches and the read-data path.
- Samples the asynchronous CPU strobes (`cs_n`, `rd_n`, `wr_n`, `a`, `d_in`) into the clock domain and decodes writes into mode-set, BSR or port-latch updates.
- Muxes port input pins onto the read bus.

---
 rtl/ppi_bus_ctrl_pkg.sv | 62 ++++++
 rtl/ppi_bus_ctrl_sync.sv | 42 ++++
 rtl/ppi_bus_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_ppi_bus_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppi_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ppi_pkg
//  Purpose : Shared constants, control-word bit positions, FSM state encoding
//            and the read-data selection helper for the 8255A bus/control
//            stage.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package ppi_pkg;

  // Register addresses presented on a[1:0]
  localparam logic [1:0] ADDR_PA   = 2'b00;
  localparam logic [1:0] ADDR_PB   = 2'b01;
  localparam logic [1:0] ADDR_PC   = 2'b10;
  localparam logic [1:0] ADDR_CTRL = 2'b11;

  // Control word after reset: mode 0, every port an input
  localparam logic [7:0] RESET_CW = 8'h9B;

  // Control-word bit positions (direction bits: 1 = input)
  localparam int MODE_FLAG = 7;
  localparam int DIR_A     = 4;
  localparam int DIR_CU    = 3;
  localparam int DIR_B     = 1;
  localparam int DIR_CL    = 0;

  // Bus-cycle FSM states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_ACT   = 2'd1,
    ST_RD_ACT   = 2'd2,
    ST_CONFLICT = 2'd3
  } ppi_state_e;

  // Read-bus value for a register address. Ports configured as inputs
  // return their pins, ports configured as outputs return their latch.
  // Port C is split into independently directed nibbles.
  function automatic logic [7:0] read_mux(
    input logic [1:0] addr,
    input logic [7:0] cw,
    input logic [7:0] pa_pin,
    input logic [7:0] pb_pin,
    input logic [7:0] pc_pin,
    input logic [7:0] pa_lat,
    input logic [7:0] pb_lat,
    input logic [7:0] pc_lat
  );
    logic [7:0] v;
    v = 8'h00;
    case (addr)
      ADDR_PA:   v = cw[DIR_A] ? pa_pin : pa_lat;
      ADDR_PB:   v = cw[DIR_B] ? pb_pin : pb_lat;
      ADDR_PC:   v = {cw[DIR_CU] ? pc_pin[7:4] : pc_lat[7:4],
                      cw[DIR_CL] ? pc_pin[3:0] : pc_lat[3:0]};
      ADDR_CTRL: v = 8'hFF;  // control register is write-only
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ppi_bus_ctrl_sync.sv
`default_nettype none
// ============================================================================
//  Module  : ppi_sync
//  Purpose : STAGES-deep flop chain bringing an asynchronous bus into the clk
//            domain. All bits of one instance move together, so a group of
//            signals sampled on the same edge stays aligned at the output.
//  Ports   : clk      - system clock
//            reset_n  - asynchronous active-low reset (chain loads RST_VAL)
//            i_d      - asynchronous input bus
//            o_q      - synchronized output bus
//  Rev     : 1.0  initial release
// ============================================================================
module ppi_sync #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_chain [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_chain[i] <= RST_VAL;
      end
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ppi_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : ppi_bus_ctrl
//  Purpose : 8255A bus interface and control register. Synchronizes the CPU
//            strobes, decodes writes into mode-set / bit-set-reset / port
//            latch updates and drives registered read data.
//  Ports   : clk, reset_n         - clock, async active-low reset
//            cs_n, rd_n, wr_n     - asynchronous CPU strobes (active low)
//            a[1:0], d_in[7:0]    - CPU address and write data
//            d_out[7:0], d_oe     - read data and read-bus drive enable
//            controlword[7:0]     - current mode word for the port blocks
//            pa/pb/pc_out[7:0]    - port output latches
//            pa/pb/pc_in[7:0]     - port pins
//            mode_set, bsr        - one-cycle commit pulses
//  Rev     : 1.0  initial release
// ============================================================================
module ppi_bus_ctrl #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_CW    = ppi_pkg::RESET_CW
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [1:0] a,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic [7:0] controlword,
  output logic [7:0] pa_out,
  output logic [7:0] pb_out,
  output logic [7:0] pc_out,
  input  logic [7:0] pa_in,
  input  logic [7:0] pb_in,
  input  logic [7:0] pc_in,
  output logic       mode_set,
  output logic       bsr
);

  import ppi_pkg::*;

  // --------------------------------------------------------------------------
  // Input synchronization. Strobes idle high, so their chain resets to 1;
  // address/data reset to 0. Both chains have equal depth, keeping address
  // and data aligned with the strobes.
  // --------------------------------------------------------------------------
  logic [2:0] w_strb_s;
  logic [9:0] w_bus_s;

  ppi_sync #(
    .WIDTH   (3),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (3'b111)
  ) u_sync_strb (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     ({cs_n, rd_n, wr_n}),
    .o_q     (w_strb_s)
  );

  ppi_sync #(
    .WIDTH   (10),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (10'h000)
  ) u_sync_bus (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     ({a, d_in}),
    .o_q     (w_bus_s)
  );

  // Active-high synchronized views
  logic       w_s_cs;
  logic       w_s_rd;
  logic       w_s_wr;
  logic [1:0] w_s_a;
  logic [7:0] w_s_d;

  assign w_s_cs = ~w_strb_s[2];
  assign w_s_rd = ~w_strb_s[1];
  assign w_s_wr = ~w_strb_s[0];
  assign w_s_a  = w_bus_s[9:8];
  assign w_s_d  = w_bus_s[7:0];

  // --------------------------------------------------------------------------
  // Bus-cycle FSM with all outputs registered
  // --------------------------------------------------------------------------
  ppi_state_e r_state;
  logic [1:0] r_addr;
  logic [7:0] r_data;
  logic [7:0] r_cw;
  logic [7:0] r_pa;
  logic [7:0] r_pb;
  logic [7:0] r_pc;
  logic [7:0] r_dout;
  logic       r_doe;
  logic       r_mode_set;
  logic       r_bsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= 2'b00;
      r_data     <= 8'h00;
      r_cw       <= RESET_CW;
      r_pa       <= 8'h00;
      r_pb       <= 8'h00;
      r_pc       <= 8'h00;
      r_dout     <= 8'h00;
      r_doe      <= 1'b0;
      r_mode_set <= 1'b0;
      r_bsr      <= 1'b0;
    end else begin
      // Commit pulses are single-cycle by default
      r_mode_set <= 1'b0;
      r_bsr      <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_s_cs) begin
            if (w_s_rd && w_s_wr) begin
              r_state <= ST_CONFLICT;
            end else if (w_s_wr) begin
              r_state <= ST_WR_ACT;
              r_addr  <= w_s_a;
              r_data  <= w_s_d;
            end else if (w_s_rd) begin
              // Drive valid data on the same edge d_oe rises, using the
              // address being captured rather than the stale r_addr.
              r_state <= ST_RD_ACT;
              r_addr  <= w_s_a;
              r_doe   <= 1'b1;
              r_dout  <= read_mux(w_s_a, r_cw, pa_in, pb_in, pc_in,
                                  r_pa, r_pb, r_pc);
            end
          end
        end

        ST_WR_ACT: begin
          // A read strobe overlapping a write aborts it without commit.
          // cs_n is deliberately ignored here: the address is already held.
          if (w_s_rd) begin
            r_state <= ST_CONFLICT;
          end else if (!w_s_wr) begin
            r_state <= ST_IDLE;
            case (r_addr)
              ADDR_PA: r_pa <= r_data;
              ADDR_PB: r_pb <= r_data;
              ADDR_PC: r_pc <= r_data;
              ADDR_CTRL: begin
                if (r_data[MODE_FLAG]) begin
                  // Mode set also clears every output latch
                  r_cw       <= r_data;
                  r_pa       <= 8'h00;
                  r_pb       <= 8'h00;
                  r_pc       <= 8'h00;
                  r_mode_set <= 1'b1;
                end else begin
                  // Bit set/reset: d[3:1] selects the port C bit, d[0] value
                  r_pc[r_data[3:1]] <= r_data[0];
                  r_bsr             <= 1'b1;
                end
              end
            endcase
          end else begin
            // Data is only taken while the strobe is still asserted, so a
            // CPU changing d_in after releasing wr_n cannot corrupt it.
            r_data <= w_s_d;
          end
        end

        ST_RD_ACT: begin
          if (!w_s_rd || !w_s_cs) begin
            r_state <= ST_IDLE;
            r_doe   <= 1'b0;
          end else begin
            r_dout <= read_mux(r_addr, r_cw, pa_in, pb_in, pc_in,
                               r_pa, r_pb, r_pc);
          end
        end

        ST_CONFLICT: begin
          r_doe <= 1'b0;
          if (!w_s_rd && !w_s_wr) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_doe   <= 1'b0;
        end
      endcase
    end
  end

  assign d_out       = r_dout;
  assign d_oe        = r_doe;
  assign controlword = r_cw;
  assign pa_out      = r_pa;
  assign pb_out      = r_pb;
  assign pc_out      = r_pc;
  assign mode_set    = r_mode_set;
  assign bsr         = r_bsr;

endmodule
`default_nettype wire

// File: tb/tb_ppi_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ppi_bus_ctrl
//  Purpose : Self-checking bench for ppi_bus_ctrl: table of write/read bus
//            cycles with hand-computed expectations plus directed sequences
//            for reset, strobe conflicts and reset during a write.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_ppi_bus_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cs_n, rd_n, wr_n;
  logic [1:0] a;
  logic [7:0] d_in, pa_in, pb_in, pc_in;
  logic [7:0] d_out, controlword, pa_out, pb_out, pc_out;
  logic       d_oe, mode_set, bsr;

  int checks   = 0;
  int failures = 0;

  // Expected architectural state, maintained by the bench
  logic [7:0] e_cw, e_pa, e_pb, e_pc;

  always #5 clk = ~clk;

  ppi_bus_ctrl #(
    .SYNC_STAGES (2),
    .RESET_CW    (8'h9B)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cs_n        (cs_n),
    .rd_n        (rd_n),
    .wr_n        (wr_n),
    .a           (a),
    .d_in        (d_in),
    .d_out       (d_out),
    .d_oe        (d_oe),
    .controlword (controlword),
    .pa_out      (pa_out),
    .pb_out      (pb_out),
    .pc_out      (pc_out),
    .pa_in       (pa_in),
    .pb_in       (pb_in),
    .pc_in       (pc_in),
    .mode_set    (mode_set),
    .bsr         (bsr)
  );

  typedef struct {
    bit         rd;
    logic [1:0] addr;
    logic [7:0] data;
    logic [7:0] pa_i, pb_i, pc_i;
    logic [7:0] x_cw, x_pa, x_pb, x_pc;
    logic [7:0] x_dout;
    bit         x_ms, x_bsr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mkw(input logic [1:0] addr, input logic [7:0] data,
                               input logic [7:0] cw, input logic [7:0] pa,
                               input logic [7:0] pb, input logic [7:0] pc,
                               input bit ms, input bit bs);
    vec_t v;
    v.rd = 1'b0; v.addr = addr; v.data = data;
    v.pa_i = 8'h00; v.pb_i = 8'h00; v.pc_i = 8'h00;
    v.x_cw = cw; v.x_pa = pa; v.x_pb = pb; v.x_pc = pc;
    v.x_dout = 8'h00; v.x_ms = ms; v.x_bsr = bs;
    return v;
  endfunction

  function automatic vec_t mkr(input logic [1:0] addr, input logic [7:0] pai,
                               input logic [7:0] pbi, input logic [7:0] pci,
                               input logic [7:0] dout);
    vec_t v;
    v.rd = 1'b1; v.addr = addr; v.data = 8'h00;
    v.pa_i = pai; v.pb_i = pbi; v.pc_i = pci;
    v.x_cw = 8'h00; v.x_pa = 8'h00; v.x_pb = 8'h00; v.x_pc = 8'h00;
    v.x_dout = dout; v.x_ms = 1'b0; v.x_bsr = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".cw"}, controlword, e_cw);
    chk({tag, ".pa"}, pa_out, e_pa);
    chk({tag, ".pb"}, pb_out, e_pb);
    chk({tag, ".pc"}, pc_out, e_pc);
  endtask

  // Full write cycle. Outputs must hold through the 2nd edge after wr_n
  // rises and take the new values on the 3rd, with a single-cycle pulse.
  task automatic do_write(input string tag, input logic [1:0] addr, input logic [7:0] data,
                          input logic [7:0] n_cw, input logic [7:0] n_pa,
                          input logic [7:0] n_pb, input logic [7:0] n_pc,
                          input bit x_ms, input bit x_bsr);
    int ms_edge, ms_cnt, bs_edge, bs_cnt;
    ms_edge = 0; ms_cnt = 0; bs_edge = 0; bs_cnt = 0;
    @(negedge clk);
    cs_n = 1'b0; a = addr; d_in = data; wr_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    wr_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 2) chk_state({tag, ".hold"});
      if (mode_set) begin ms_cnt++; if (ms_edge == 0) ms_edge = k; end
      if (bsr)      begin bs_cnt++; if (bs_edge == 0) bs_edge = k; end
    end
    cs_n = 1'b1;
    e_cw = n_cw; e_pa = n_pa; e_pb = n_pb; e_pc = n_pc;
    chk_state(tag);
    chk({tag, ".ms_edge"},  8'(ms_edge), x_ms  ? 8'd3 : 8'd0);
    chk({tag, ".ms_cnt"},   8'(ms_cnt),  x_ms  ? 8'd1 : 8'd0);
    chk({tag, ".bsr_edge"}, 8'(bs_edge), x_bsr ? 8'd3 : 8'd0);
    chk({tag, ".bsr_cnt"},  8'(bs_cnt),  x_bsr ? 8'd1 : 8'd0);
    repeat (2) tick();
  endtask

  // Full read cycle: d_oe rises on the 3rd edge after rd_n falls and falls
  // on the 3rd edge after rd_n rises.
  task automatic do_read(input string tag, input logic [1:0] addr, input logic [7:0] pai,
                         input logic [7:0] pbi, input logic [7:0] pci, input logic [7:0] x_dout);
    @(negedge clk);
    pa_in = pai; pb_in = pbi; pc_in = pci;
    cs_n = 1'b0; a = addr; rd_n = 1'b0;
    tick(); chk({tag, ".oe_e1"}, {7'd0, d_oe}, 8'd0);
    tick(); chk({tag, ".oe_e2"}, {7'd0, d_oe}, 8'd0);
    tick(); chk({tag, ".oe_e3"}, {7'd0, d_oe}, 8'd1);
    chk({tag, ".dout"}, d_out, x_dout);
    tick(); tick();
    chk({tag, ".dout_hold"}, d_out, x_dout);
    @(negedge clk);
    rd_n = 1'b1;
    tick(); chk({tag, ".oe_r1"}, {7'd0, d_oe}, 8'd1);
    tick(); chk({tag, ".oe_r2"}, {7'd0, d_oe}, 8'd1);
    tick(); chk({tag, ".oe_r3"}, {7'd0, d_oe}, 8'd0);
    @(negedge clk);
    cs_n = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    int pulses;
    bit oe_seen;

    reset_n = 1'b0;
    cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    a = 2'b00; d_in = 8'h00; pa_in = 8'h00; pb_in = 8'h00; pc_in = 8'h00;
    e_cw = 8'h9B; e_pa = 8'h00; e_pb = 8'h00; e_pc = 8'h00;

    // ---------------- power-on reset ----------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk_state("por");
    chk("por.doe", {7'd0, d_oe}, 8'd0);
    chk("por.dout", d_out, 8'h00);
    chk("por.pulses", {6'd0, mode_set, bsr}, 8'd0);

    // Put something in a latch, then reset between edges
    do_write("pre", 2'b00, 8'h11, 8'h9B, 8'h11, 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    e_cw = 8'h9B; e_pa = 8'h00; e_pb = 8'h00; e_pc = 8'h00;
    chk_state("async_rst");
    chk("async_rst.doe", {7'd0, d_oe}, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // ---------------- table-driven bus cycles ----------------
    vt.push_back(mkw(2'b11, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 1, 0));
    vt.push_back(mkw(2'b00, 8'h5A, 8'h80, 8'h5A, 8'h00, 8'h00, 0, 0));
    vt.push_back(mkw(2'b01, 8'hC3, 8'h80, 8'h5A, 8'hC3, 8'h00, 0, 0));
    vt.push_back(mkw(2'b11, 8'h0F, 8'h80, 8'h5A, 8'hC3, 8'h80, 0, 1));
    vt.push_back(mkw(2'b11, 8'h0E, 8'h80, 8'h5A, 8'hC3, 8'h00, 0, 1));
    vt.push_back(mkw(2'b11, 8'h05, 8'h80, 8'h5A, 8'hC3, 8'h04, 0, 1));
    vt.push_back(mkw(2'b10, 8'h3C, 8'h80, 8'h5A, 8'hC3, 8'h3C, 0, 0));
    vt.push_back(mkw(2'b11, 8'h88, 8'h88, 8'h00, 8'h00, 8'h00, 1, 0));
    vt.push_back(mkw(2'b10, 8'h03, 8'h88, 8'h00, 8'h00, 8'h03, 0, 0));
    vt.push_back(mkw(2'b00, 8'h5A, 8'h88, 8'h5A, 8'h00, 8'h03, 0, 0));
    vt.push_back(mkw(2'b01, 8'h69, 8'h88, 8'h5A, 8'h69, 8'h03, 0, 0));
    vt.push_back(mkr(2'b10, 8'h00, 8'h00, 8'hA5, 8'hA3));
    vt.push_back(mkr(2'b00, 8'hFF, 8'h00, 8'h00, 8'h5A));
    vt.push_back(mkr(2'b01, 8'h00, 8'h00, 8'h00, 8'h69));
    vt.push_back(mkr(2'b11, 8'h12, 8'h34, 8'h56, 8'hFF));
    vt.push_back(mkw(2'b11, 8'h9B, 8'h9B, 8'h00, 8'h00, 8'h00, 1, 0));
    vt.push_back(mkr(2'b00, 8'h12, 8'h00, 8'h00, 8'h12));
    vt.push_back(mkr(2'b01, 8'h00, 8'h34, 8'h00, 8'h34));
    vt.push_back(mkr(2'b10, 8'h00, 8'h00, 8'h56, 8'h56));
    vt.push_back(mkw(2'b11, 8'h83, 8'h83, 8'h00, 8'h00, 8'h00, 1, 0));
    vt.push_back(mkw(2'b10, 8'hF0, 8'h83, 8'h00, 8'h00, 8'hF0, 0, 0));
    vt.push_back(mkw(2'b00, 8'hE1, 8'h83, 8'hE1, 8'h00, 8'hF0, 0, 0));
    vt.push_back(mkr(2'b10, 8'h00, 8'h00, 8'h3C, 8'hFC));
    vt.push_back(mkr(2'b00, 8'h00, 8'h00, 8'h00, 8'hE1));
    vt.push_back(mkr(2'b01, 8'h00, 8'h7E, 8'h00, 8'h7E));

    for (int i = 0; i < vt.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      if (vt[i].rd)
        do_read(tag, vt[i].addr, vt[i].pa_i, vt[i].pb_i, vt[i].pc_i, vt[i].x_dout);
      else
        do_write(tag, vt[i].addr, vt[i].data, vt[i].x_cw, vt[i].x_pa,
                 vt[i].x_pb, vt[i].x_pc, vt[i].x_ms, vt[i].x_bsr);
    end

    // ---------------- simultaneous rd/wr conflict ----------------
    pulses = 0; oe_seen = 1'b0;
    @(negedge clk);
    cs_n = 1'b0; a = 2'b00; d_in = 8'hFF; rd_n = 1'b0; wr_n = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (d_oe) oe_seen = 1'b1;
    end
    @(negedge clk);
    rd_n = 1'b1; wr_n = 1'b1; cs_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (d_oe) oe_seen = 1'b1;
      if (mode_set || bsr) pulses++;
    end
    chk_state("conf");
    chk("conf.doe_seen", {7'd0, oe_seen}, 8'd0);
    chk("conf.pulses", 8'(pulses), 8'd0);

    // ---------------- read arriving during an active write ----------------
    pulses = 0; oe_seen = 1'b0;
    @(negedge clk);
    cs_n = 1'b0; a = 2'b00; d_in = 8'hFF; wr_n = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    rd_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (d_oe) oe_seen = 1'b1;
    end
    @(negedge clk);
    rd_n = 1'b1; wr_n = 1'b1; cs_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (d_oe) oe_seen = 1'b1;
      if (mode_set || bsr) pulses++;
    end
    chk_state("wr_conf");
    chk("wr_conf.doe_seen", {7'd0, oe_seen}, 8'd0);
    chk("wr_conf.pulses", 8'(pulses), 8'd0);

    // Next clean writes commit normally
    do_write("post_conf", 2'b00, 8'hA7, 8'h83, 8'hA7, 8'h00, 8'hF0, 1'b0, 1'b0);
    do_write("pb_set",    2'b01, 8'hC3, 8'h83, 8'hA7, 8'hC3, 8'hF0, 1'b0, 1'b0);

    // ---------------- reset in the middle of a write ----------------
    pulses = 0;
    @(negedge clk);
    cs_n = 1'b0; a = 2'b01; d_in = 8'h77; wr_n = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    e_cw = 8'h9B; e_pa = 8'h00; e_pb = 8'h00; e_pc = 8'h00;
    chk_state("mid_rst");
    chk("mid_rst.doe", {7'd0, d_oe}, 8'd0);
    @(negedge clk);
    wr_n = 1'b1; cs_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (mode_set || bsr) pulses++;
    end
    chk_state("mid_rst.after");
    chk("mid_rst.pulses", 8'(pulses), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
